// File: rtl/ack_merge.sv
// Merges CH_NUM slave acks into one registered single-cycle ack with source index and errors.
// Optional no-ack timeout is enabled by defining ACK_TIMEOUT_EN.
module ack_merge #(
    parameter int CH_NUM  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [CH_NUM-1:0]         ack_in,
    output logic                      ack,
    output logic [$clog2(CH_NUM)-1:0] ack_src,
    output logic                      err_multi,
    output logic                      err_timeout,
    output logic                      busy
);

    localparam int SW = $clog2(CH_NUM);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e        st_q, st_d;
    logic          ack_q, ack_d;
    logic [SW-1:0] src_q, src_d;
    logic          multi_q, multi_d;
    logic          tmo_q, tmo_d;
    logic [SW-1:0] low_idx;
    logic          multi_hit;
    logic          tmo_hit;

`ifdef ACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts WAIT cycles; cleared everywhere else so a new request starts at 0.
    always_comb begin
        cnt_d = '0;
        if (st_q == StWait) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (st_q == StWait) && (cnt_q == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Descending scan leaves the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (ack_in[i]) begin
                low_idx = SW'(i);
            end
        end
    end

    assign multi_hit = (ack_in & (ack_in - CH_NUM'(1))) != '0;

    always_comb begin
        st_d    = st_q;
        ack_d   = 1'b0;
        src_d   = src_q;
        multi_d = multi_q;
        tmo_d   = tmo_q;
        case (st_q)
            StIdle: begin
                if (req) begin
                    st_d = StWait;
                end
            end
            StWait: begin
                if (!req) begin
                    st_d = StIdle;
                end else if (|ack_in) begin
                    st_d    = StDone;
                    ack_d   = 1'b1;
                    src_d   = low_idx;
                    multi_d = multi_hit;
                    tmo_d   = 1'b0;
                end else if (tmo_hit) begin
                    st_d    = StDone;
                    ack_d   = 1'b1;
                    src_d   = '0;
                    multi_d = 1'b0;
                    tmo_d   = 1'b1;
                end
            end
            StDone: begin
                if (!req) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= StIdle;
            ack_q   <= 1'b0;
            src_q   <= '0;
            multi_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            ack_q   <= ack_d;
            src_q   <= src_d;
            multi_q <= multi_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ack         = ack_q;
    assign ack_src     = src_q;
    assign err_multi   = multi_q;
    assign err_timeout = tmo_q;
    assign busy        = (st_q != StIdle);

endmodule

// File: doc/ack_merge.md
# ack_merge

Parametrised acknowledge combiner for a multi-slave bus. It merges `CH_NUM` slave acknowledge lines into one registered single-cycle acknowledge back to the bus master. It tracks one outstanding request at a time and reports which slave answered. It flags protocol errors: multiple simultaneous acks and, optionally, no ack within a timeout. It sits between the bus master's request logic and the slave ack outputs, replacing the fixed 4-input combinational OR.

## Interface

Parameters:
- `CH_NUM`, 4, number of slave ack inputs (2..16)
- `TIMEOUT`, 16, cycles in WAIT before a timeout ack is generated (≥2; used only with `ACK_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset; asynchronous, active-low
- `req`  in  1  master request, level; held high until `ack` seen
- `ack_in`  in  `CH_NUM`  slave acks, bit i from slave i, active-high
- `ack`  out  1  merged ack to master, one-cycle pulse
- `ack_src`  out  `$clog2(CH_NUM)`  index of the answering slave, valid while `ack`=1
- `err_multi`  out  1  more than one `ack_in` bit set at capture, valid with `ack`
- `err_timeout`  out  1  ack generated by timeout, valid with `ack`
- `busy`  out  1  high in WAIT and DONE

## Operation

- FSM states are IDLE, WAIT and DONE. Reset state is IDLE.
- IDLE:
  - `req`=1 at an edge → WAIT; timeout counter cleared to 0.
  - `ack_in` is ignored.
- WAIT:
  - `req`=0 → IDLE (abort); no `ack`, no error.
  - Else any `ack_in` bit =1 → capture and go to DONE.
    - `ack`=1 the next cycle.
    - `ack_src` = lowest set bit index.
    - `err_multi` = (popcount > 1).
  - Else, if the counter = `TIMEOUT`-1 → DONE with `ack`=1, `err_timeout`=1, `ack_src`=0.
    - Applies only with `ACK_TIMEOUT_EN`.
  - Otherwise the counter increments.
  - Slave ack wins over timeout in the same cycle.
- DONE: stay until `req`=0, then → IDLE. `ack_in` is ignored. A still-high `req` never retriggers.
- Outputs are registered.
  - `ack` is high exactly one cycle, the first cycle in DONE.
  - `ack_src`, `err_multi` and `err_timeout` hold their values until the next capture. They are zero after reset.
- Counter width: `$clog2(TIMEOUT+1)`. The counter never wraps, because WAIT exits at `TIMEOUT`-1.

## Timing

- Reset (`rst`=0, any time, asynchronous):
  - State → IDLE; counter → 0.
  - `ack`, `ack_src`, `err_multi`, `err_timeout`, `busy` → 0.
  - A request in flight is dropped.
- Edge-by-edge sequence:
  - Edge n: `req` sampled high in IDLE; WAIT and `busy`=1 from edge n.
  - Edge m > n: `ack_in` sampled in WAIT; `ack`=1 from edge m until edge m+1.
  - Minimum latency, `req` to `ack`: 2 edges.
- Timeout: with no slave ack, `ack`+`err_timeout` rise at edge n+`TIMEOUT`.
- `busy` falls on the edge that samples `req`=0 in DONE or WAIT.
- Back-to-back requests need `req` low for at least one edge between them.

## Configuration

- `ACK_TIMEOUT_EN` defined:
  - Timeout counter present.
  - Behaviour as above.
- Not defined:
  - No counter.
  - `err_timeout` is tied to 0.
  - WAIT persists until a slave ack or `req` abort.
  - `TIMEOUT` is ignored.

## Test plan

- Reset defaults, `CH_NUM`=4:
  - Stimulus: reset low, `ack_in`=4'b0000.
  - Required: all outputs 0; `busy`=0.
- Single slave ack:
  - Stimulus: `req`=1, then `ack_in`=4'b0100 two cycles later.
  - Required: `ack` pulses exactly one cycle with `ack_src`=2, `err_multi`=0.
  - Then: `busy` stays 1 until `req`=0.
- Multiple acks:
  - Stimulus: `ack_in`=4'b1010 in WAIT.
  - Required: `ack`=1, `ack_src`=1, `err_multi`=1.
  - Stimulus: `ack_in` set in IDLE/DONE.
  - Required: no `ack`.
- Timeout, `ACK_TIMEOUT_EN` defined, `TIMEOUT`=16:
  - Stimulus: `req`=1, `ack_in`=0.
  - Required: `ack`=1, `err_timeout`=1 exactly 16 edges after `req` capture.
  - Stimulus: slave ack on cycle 15.
  - Required: `err_timeout`=0.
  - Without the macro: no ack after 100 cycles.
- Abort and reset:
  - Stimulus: `req` dropped in WAIT.
  - Required: return to IDLE, no `ack`.
  - Stimulus: `rst` low for half a cycle in DONE.
  - Required: outputs 0 immediately, state IDLE.
- Sequential walk:
  - Stimulus: acks from slaves 0,1,2,3 on four consecutive requests.
  - Required: `ack_src` 0,1,2,3 in order, `err_multi`=0 throughout.
